// File: rtl/chan_arb_pkg.sv
// Shared header-field constants and one-hot FSM encoding for the channel arbiter.
package chan_arb_pkg;

    localparam int HDR_FLAG_BIT   = 15;
    localparam int HDR_MASTER_BIT = 14;
    localparam int HDR_NUM_MSB    = 13;
    localparam int HDR_NUM_LSB    = 8;
    localparam int HDR_LEN_MSB    = 7;
    localparam int HDR_LEN_LSB    = 0;

    localparam logic [3:0] ST_IDLE  = 4'b0001;
    localparam logic [3:0] ST_HDR   = 4'b0010;
    localparam logic [3:0] ST_HWAIT = 4'b0100;
    localparam logic [3:0] ST_BODY  = 4'b1000;

    typedef enum logic [3:0] {
        IDLE  = ST_IDLE,
        HDR   = ST_HDR,
        HWAIT = ST_HWAIT,
        BODY  = ST_BODY
    } arb_state_e;

endpackage

// File: rtl/arb_skid_fifo.sv
// Output skid FIFO: DEPTH entries of {data, sop, eop}; push while full is legal when popping.
module arb_skid_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18,
    localparam int AW   = $clog2(DEPTH),
    localparam int FW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [FW-1:0]    free_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [FW-1:0]    count_q;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == FW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign free_o  = FW'(DEPTH) - count_q;
    assign doPop   = pop_i && !empty_o;
    assign doPush  = push_i && (!full_o || doPop);
    assign data_o  = mem[rdPtr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
            count_q <= count_q + FW'(doPush) - FW'(doPop);
        end
    end

    // Storage needs no reset: the head is only meaningful while not empty.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr_q] <= data_i;
    end

endmodule

// File: rtl/chan_arbiter.sv
// Round-robin block arbiter: drains whole channel blocks onto one 16-bit valid/ready stream.
// Define ARB_BLKCNT_EN to add the blk_cnt / err_cnt statistics outputs.
module chan_arbiter
    import chan_arb_pkg::*;
#(
    parameter int NCH        = 16,
    parameter int SKID_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    req,
    output logic [NCH-1:0]    ack,
    input  logic [16*NCH-1:0] din,
    output logic [15:0]       dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_sop,
    output logic              dout_eop,
    output logic [5:0]        cur_chan,
    output logic              busy,
    output logic              hdr_err
`ifdef ARB_BLKCNT_EN
    ,
    output logic [31:0]       blk_cnt,
    output logic [15:0]       err_cnt
`endif
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int FW = $clog2(SKID_DEPTH) + 1;

    arb_state_e    state_q, state_d;
    logic [CW-1:0] curIdx_q, curIdx_d;
    logic [CW-1:0] ptr_q, ptr_d;
    logic [8:0]    remaining_q, remaining_d;
    logic          pending_q, pending_d;
    logic          hdrErr_q, hdrErr_d;

    logic          ackEn;
    logic          fifoPush;
    logic [17:0]   pushWord;
    logic          fifoPop;
    logic [17:0]   head;
    logic          fifoFull;
    logic          fifoEmpty;
    logic [FW-1:0] fifoFree;
    logic          spaceOk;
    logic [15:0]   chWord;
    logic [8:0]    hdrLen;
    logic          found;
    logic [CW-1:0] selIdx;
    logic [CW:0]   idxW;

    arb_skid_fifo #(.DEPTH(SKID_DEPTH), .WIDTH(18)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifoPush),
        .data_i  (pushWord),
        .pop_i   (fifoPop),
        .data_o  (head),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .free_o  (fifoFree)
    );

    // A word already in flight from last cycle's ack must be counted against free space.
    assign spaceOk = !fifoFull && (fifoFree >= (pending_q ? FW'(3) : FW'(2)));
    assign chWord  = din[{curIdx_q, 4'b0000} +: 16];
    assign hdrLen  = {1'b0, chWord[HDR_LEN_MSB:HDR_LEN_LSB]} + 9'(chWord[HDR_MASTER_BIT]);

    always_comb begin
        found  = 1'b0;
        selIdx = '0;
        idxW   = '0;
        for (int k = 1; k <= NCH; k++) begin
            idxW = {1'b0, ptr_q} + (CW+1)'(k);
            if (idxW >= (CW+1)'(NCH)) idxW = idxW - (CW+1)'(NCH);
            if (!found && req[idxW[CW-1:0]]) begin
                found  = 1'b1;
                selIdx = idxW[CW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        curIdx_d    = curIdx_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        hdrErr_d    = 1'b0;
        ackEn       = 1'b0;
        fifoPush    = 1'b0;
        pushWord    = '0;
        unique case (state_q)
            IDLE: begin
                if (found && spaceOk) begin
                    curIdx_d = selIdx;
                    state_d  = HDR;
                end
            end
            HDR: begin
                ackEn   = 1'b1;
                state_d = HWAIT;
            end
            HWAIT: begin
                fifoPush = 1'b1;
                pushWord = {chWord, 1'b1, 1'b0};
                if (!chWord[HDR_FLAG_BIT]) begin
                    pushWord[0] = 1'b1;
                    hdrErr_d    = 1'b1;
                    ptr_d       = curIdx_q;
                    state_d     = IDLE;
                end else if (hdrLen == 9'd0) begin
                    pushWord[0] = 1'b1;
                    ptr_d       = curIdx_q;
                    state_d     = IDLE;
                end else begin
                    remaining_d = hdrLen;
                    state_d     = BODY;
                end
            end
            BODY: begin
                if (pending_q) begin
                    fifoPush    = 1'b1;
                    pushWord    = {chWord, 1'b0, remaining_q == 9'd1};
                    remaining_d = remaining_q - 9'd1;
                    if (remaining_q == 9'd1) begin
                        ptr_d   = curIdx_q;
                        state_d = IDLE;
                    end
                end
                // Never ack beyond the block length, even with one word still in flight.
                if ((remaining_q > {8'b0, pending_q}) && spaceOk) ackEn = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        pending_d = ackEn;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            curIdx_q    <= '0;
            ptr_q       <= CW'(NCH - 1);
            remaining_q <= '0;
            pending_q   <= 1'b0;
            hdrErr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            curIdx_q    <= curIdx_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            pending_q   <= pending_d;
            hdrErr_q    <= hdrErr_d;
        end
    end

    assign ack        = ackEn ? (NCH'(1) << curIdx_q) : '0;
    assign dout_valid = !fifoEmpty;
    assign fifoPop    = dout_valid && dout_ready;
    assign dout       = dout_valid ? head[17:2] : 16'h0000;
    assign dout_sop   = dout_valid && head[1];
    assign dout_eop   = dout_valid && head[0];
    assign cur_chan   = 6'(curIdx_q);
    assign busy       = (state_q != IDLE);
    assign hdr_err    = hdrErr_q;

`ifdef ARB_BLKCNT_EN
    // Blocks counted as their last word leaves; the error count sticks at its maximum.
    logic [31:0] blkCnt_q;
    logic [15:0] errCnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blkCnt_q <= '0;
            errCnt_q <= '0;
        end else begin
            if (fifoPop && head[0]) blkCnt_q <= blkCnt_q + 32'd1;
            if (hdrErr_q && (errCnt_q != 16'hFFFF)) errCnt_q <= errCnt_q + 16'd1;
        end
    end

    assign blk_cnt = blkCnt_q;
    assign err_cnt = errCnt_q;
`endif

endmodule

// File: tb/tb_chan_arbiter.sv
// Directed bench for chan_arbiter: channel FIFO models feed blocks, output words are scoreboarded.
module tb_chan_arbiter;

    logic          clk;
    logic          rst_n;
    logic [15:0]   req;
    logic [15:0]   ack;
    logic [255:0]  din;
    logic [15:0]   dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_sop;
    logic          dout_eop;
    logic [5:0]    cur_chan;
    logic          busy;
    logic          hdr_err;
`ifdef ARB_BLKCNT_EN
    logic [31:0]   blk_cnt;
    logic [15:0]   err_cnt;
`endif

    int            checkCount;
    int            failCount;

    logic [15:0]   chMem [16][64];
    int            wrIdx [16];
    int            rdIdx [16];
    int            ackCount [16];
    int            multiAck;
    int            hdrErrCount;
    logic [17:0]   capQ [$];
    logic [17:0]   expQ [$];
    int            capBase;

    chan_arbiter #(.NCH(16), .SKID_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .ack        (ack),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_sop   (dout_sop),
        .dout_eop   (dout_eop),
        .cur_chan   (cur_chan),
        .busy       (busy),
        .hdr_err    (hdr_err)
`ifdef ARB_BLKCNT_EN
        ,
        .blk_cnt    (blk_cnt),
        .err_cnt    (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Channel FIFO model: a block is "available" whenever unread words remain.
    always_comb begin
        req = '0;
        for (int i = 0; i < 16; i++) req[i] = (wrIdx[i] != rdIdx[i]);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) rdIdx[i] <= wrIdx[i];
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (ack[i]) begin
                    din[16*i +: 16] <= chMem[i][rdIdx[i] % 64];
                    rdIdx[i]        <= rdIdx[i] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && dout_valid && dout_ready) capQ.push_back({dout, dout_sop, dout_eop});
        if (hdr_err) hdrErrCount++;
        if ($countones(ack) > 1) multiAck++;
        for (int i = 0; i < 16; i++) if (ack[i]) ackCount[i]++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Loads one block into a channel model and queues the words the stream must carry.
    task automatic applyStimulus(input int ch, input logic [15:0] hdr, input logic [15:0] firstData);
        int total;
        logic [15:0] w;
        total = hdr[15] ? (int'(hdr[7:0]) + int'(hdr[14]) + 1) : 1;
        for (int k = 0; k < total; k++) begin
            w = (k == 0) ? hdr : firstData + 16'(k - 1);
            chMem[ch][wrIdx[ch] % 64] = w;
            wrIdx[ch] = wrIdx[ch] + 1;
            expQ.push_back({w, k == 0, k == total - 1});
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitAndCompare(input string tag, input int budget, input logic [3:0] pat);
        int cyc;
        int n;
        cyc = 0;
        n = expQ.size();
        while (((capQ.size() - capBase) < n) && (cyc < budget)) begin
            dout_ready = pat[cyc[1:0]];
            tick(1);
            cyc++;
        end
        dout_ready = 1'b1;
        checkOutput({tag, "_count"}, 32'(capQ.size() - capBase), 32'(n));
        for (int i = 0; i < n; i++) begin
            if ((capBase + i) < capQ.size())
                checkOutput($sformatf("%s_w%0d", tag, i), 32'(capQ[capBase + i]), 32'(expQ[i]));
        end
        capBase = capBase + n;
        expQ.delete();
    endtask

    task automatic waitBusy(input string tag);
        int cyc;
        cyc = 0;
        while (!busy && (cyc < 20)) begin
            tick(1);
            cyc++;
        end
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ack"}, 32'(ack), 32'h0);
        checkOutput({tag, "_dout"}, 32'(dout), 32'h0);
        checkOutput({tag, "_valid"}, 32'(dout_valid), 32'h0);
        checkOutput({tag, "_sop"}, 32'(dout_sop), 32'h0);
        checkOutput({tag, "_eop"}, 32'(dout_eop), 32'h0);
        checkOutput({tag, "_cur_chan"}, 32'(cur_chan), 32'h0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
        checkOutput({tag, "_hdr_err"}, 32'(hdr_err), 32'h0);
`ifdef ARB_BLKCNT_EN
        checkOutput({tag, "_blk_cnt"}, blk_cnt, 32'h0);
        checkOutput({tag, "_err_cnt"}, 32'(err_cnt), 32'h0);
`endif
    endtask

    initial begin
        int ackBefore;
        int errBefore;
`ifdef ARB_BLKCNT_EN
        logic [31:0] blkBefore;
        logic [15:0] errCntBefore;
`endif
        checkCount = 0;
        failCount  = 0;
        capBase    = 0;
        rst_n      = 1'b0;
        dout_ready = 1'b1;
        tick(3);
        checkResetValues("reset");
        rst_n = 1'b1;
        tick(2);

        $display("[TB] self block on ch3");
        ackBefore = ackCount[3];
        applyStimulus(3, 16'h8304, 16'h1111);
        waitBusy("ch3");
        checkOutput("ch3_cur_chan", 32'(cur_chan), 32'd3);
        waitAndCompare("ch3", 100, 4'b1111);
        tick(3);
        checkOutput("ch3_ack_cycles", 32'(ackCount[3] - ackBefore), 32'd5);

        $display("[TB] master block on ch0");
        applyStimulus(0, 16'hC002, 16'h8123);
        waitAndCompare("ch0_master", 100, 4'b1111);

        $display("[TB] zero-length self block on ch1");
        applyStimulus(1, 16'h8000, 16'h0000);
        waitAndCompare("ch1_len0", 100, 4'b1111);

        $display("[TB] round robin 1,2,5 from ptr=1");
        applyStimulus(2, 16'h8002, 16'hB200);
        applyStimulus(5, 16'hC000, 16'h5555);
        applyStimulus(1, 16'h8001, 16'hA100);
        waitAndCompare("rr", 200, 4'b1111);

        $display("[TB] 8-word block with stalls on ch6");
        applyStimulus(6, 16'h8008, 16'h6000);
        dout_ready = 1'b0;
        tick(12);
        checkOutput("stall_ack", 32'(ack), 32'h0);
        checkOutput("stall_valid", 32'(dout_valid), 32'd1);
        checkOutput("stall_head", 32'({dout, dout_sop}), 32'({16'h8008, 1'b1}));
        waitAndCompare("ch6_stall", 300, 4'b1001);

        $display("[TB] header error on ch4");
        errBefore = hdrErrCount;
`ifdef ARB_BLKCNT_EN
        errCntBefore = err_cnt;
`endif
        applyStimulus(4, 16'h0305, 16'h0000);
        waitAndCompare("ch4_err", 100, 4'b1111);
        tick(4);
        checkOutput("hdr_err_pulses", 32'(hdrErrCount - errBefore), 32'd1);
        checkOutput("err_idle_busy", 32'(busy), 32'd0);
`ifdef ARB_BLKCNT_EN
        checkOutput("err_cnt_delta", 32'(err_cnt - errCntBefore), 32'd1);

        $display("[TB] ten back-to-back blocks on ch8");
        blkBefore = blk_cnt;
        for (int b = 0; b < 10; b++) applyStimulus(8, 16'h8001, 16'h0800 + 16'(b));
        waitAndCompare("b2b", 400, 4'b1111);
        tick(2);
        checkOutput("blk_cnt_delta", blk_cnt - blkBefore, 32'd10);
`endif

        $display("[TB] reset mid-block on ch7");
        applyStimulus(7, 16'h8010, 16'h7000);
        begin
            int cyc;
            cyc = 0;
            while (((capQ.size() - capBase) < 5) && (cyc < 100)) begin
                tick(1);
                cyc++;
            end
        end
        checkOutput("midblk_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkResetValues("midrst");
        tick(2);
        capBase = capQ.size();
        expQ.delete();
        rst_n = 1'b1;
        tick(2);
        applyStimulus(7, 16'h8002, 16'h7700);
        waitAndCompare("post_reset", 100, 4'b1111);

        tick(5);
        checkOutput("one_hot_ack", 32'(multiAck), 32'd0);
        checkOutput("no_extra_words", 32'(capQ.size() - capBase), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/chan_arbiter.md
Name: chan_arbiter

Overview:
- Downstream stage of the per-channel processors. Collects complete self-trigger and master-trigger blocks from NCH channel FIFOs using their req/ack/dout interface.
- Serves channels round-robin and forwards whole blocks, never interleaved, onto one 16-bit valid/ready stream toward the event builder / VME readout.
- Parses each block header to learn the block length and marks start and end of block.

Parameters:
- NCH, 16, number of channel inputs (1..64)
- SKID_DEPTH, 4, output skid FIFO depth in words (power of 2, >=4)

Ports:
- clk  in  1  125 MHz system clock, same as the channel processors
- rst_n  in  1  asynchronous active-low reset
- req  in  NCH  per-channel "full block available"
- ack  out  NCH  per-channel read strobe, one word per asserted cycle
- din  in  16*NCH  channel data; channel i occupies bits [16*i+15:16*i]; word appears on din the cycle after its ack
- dout  out  16  output word
- dout_valid  out  1  dout holds a valid word
- dout_ready  in  1  consumer accepts word when valid&ready
- dout_sop  out  1  dout is a block header
- dout_eop  out  1  dout is last word of a block
- cur_chan  out  6  channel currently being served
- busy  out  1  block transfer in progress
- hdr_err  out  1  one-cycle pulse: header bit15 was 0

Behaviour:
- Reset values: ack=0, dout=0, dout_valid=0, dout_sop=0, dout_eop=0, cur_chan=0, busy=0, hdr_err=0. The skid FIFO is emptied. The round-robin pointer is set so that channel 0 has the highest priority.
- Channel read latency is 1: ack[i] in cycle t makes the acked word visible on din[i] in cycle t+1. At most one ack bit is high per cycle.
- An ack is issued only when the skid FIFO has at least 2 free entries, counting words already in flight. Consequence: no word is lost when dout_ready drops.
- State machine:
  - IDLE: if any req bit is set and the skid FIFO has room, pick the first requesting channel at or after ptr+1 (mod NCH). Latch cur_chan, set busy, then go to HDR. Otherwise stay in IDLE.
  - HDR: assert ack for the header. Go to HWAIT.
  - HWAIT: capture the header from din[cur_chan] and push it with sop=1.
    - If bit15=0: pulse hdr_err, push the word with eop=1, set ptr=cur_chan, go to IDLE. The channel is not drained further.
    - Otherwise remaining = hdr[7:0] + (hdr[14] ? 1 : 0). A master block carries an extra trigger word.
    - If remaining=0: mark the header eop=1 and go to IDLE.
    - Otherwise go to BODY.
  - BODY: ack whenever skid space allows. Each returned word is pushed and decrements remaining (9-bit). The word that takes remaining to 0 is pushed with eop=1. Then ptr=cur_chan, busy=0, go to IDLE.
- ack toggling in BODY is fine: stalls only delay the stream. A pending return word is always captured even if ack drops in that cycle.
- Arithmetic: remaining is 9 bits; the maximum is 255+1=256.
- Block lengths:
  - hdr[7:0]=0 with self signature → 1-word block.
  - hdr[7:0]=0 with master signature → header + trigger word.
- Output:
  - dout/dout_sop/dout_eop come from the head of the skid FIFO; dout_valid = FIFO not empty.
  - Pop on dout_valid & dout_ready. Push and pop in the same cycle are allowed when full or empty.
- req dropping while a block is in progress is ignored; the length from the header governs. req from other channels during a transfer is only sampled in IDLE.
- Reset mid-block: everything returns to reset values. Any partial channel block is abandoned; the channel's own reset realigns it.

Optional Feature:
- ARB_BLKCNT_EN defined: adds output blk_cnt [31:0].
  - Reset 0; increments by 1 on each eop word popped from the output (valid&ready&eop); wraps at 2^32.
  - Adds output err_cnt [15:0]; increments on each hdr_err; saturates at 0xFFFF.
- Not defined: neither port exists, and no counter logic is present.

Decomposition:
- Package chan_arb_pkg holds:
  - header field constants: HDR_FLAG_BIT=15, HDR_MASTER_BIT=14, HDR_NUM_MSB=13, HDR_NUM_LSB=8, HDR_LEN_MSB=7, HDR_LEN_LSB=0
  - state encoding localparams (one-hot): IDLE, HDR, HWAIT, BODY
- One sub-module, arb_skid_fifo:
  - synchronous FIFO, 18 bits wide (data+sop+eop), SKID_DEPTH deep, asynchronous active-low reset
  - flags: full, empty, free count

Test Plan:
- Self block on ch3, hdr=0x8304, 4 data words, dout_ready=1 → 5 words out. sop on 0x8304, eop on 4th data word. ack[3] high exactly 5 cycles in total.
- Master block on ch0, hdr=0xC002, trig=0x8123, 2 data words → 4 words out; eop on last data word.
- Channels 1, 2 and 5 requesting simultaneously, previous ptr=1 → service order 2, 5, 1. Blocks contiguous, never interleaved.
- 8-word block with dout_ready toggling 1-0-0-1 randomly → all words exactly once, in order; skid FIFO never overflows; ack held low while free space <2.
- Header 0x0305 (bit15=0) on ch4 → hdr_err single pulse; one word out with sop=eop=1; arbiter returns to IDLE.
- With ARB_BLKCNT_EN: 10 back-to-back blocks → blk_cnt=10. Assert rst_n=0 mid-block → all outputs at reset values; next block forwarded correctly after reset release.
